// File: rtl/system_pkg.sv
// Shared constants, FSM state types and bit-period helper for the UART echo system.
package system_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Rounded clocks per bit, never below 2 so the half-bit start offset is non-zero.
  function automatic int unsigned bit_period(input int unsigned freq, input int unsigned baud);
    int unsigned n;
    n = (freq + baud / 2) / baud;
    return (n < 2) ? 2 : n;
  endfunction

endpackage

// File: rtl/system_uart_phy.sv
// UART physical layer: rx synchronizer, 8N1 receiver and 8N1 transmitter.
module uart_phy
  import system_pkg::*;
#(
  parameter int unsigned clk_freq       = 2000000,
  parameter int unsigned uart_baud_rate = 1152000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy
);

  localparam int unsigned N    = bit_period(clk_freq, uart_baud_rate);
  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(N / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_meta, rxs;

  rx_state_t            rx_st, rx_st_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [IW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sr, rx_sr_n, rx_data_n;
  logic                 rx_valid_n;

  tx_state_t            tx_st, tx_st_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_sr, tx_sr_n;
  logic                 txd_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_st    <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sr    <= '0;
      txd      <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rx_st    <= rx_st_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sr    <= rx_sr_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_st    <= tx_st_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sr    <= tx_sr_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    rx_st_n    = rx_st;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_idx_n   = rx_idx;
    rx_sr_n    = rx_sr;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rxs) rx_st_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_st_n  = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          rx_sr_n  = {rxs, rx_sr[DATA_BITS-1:1]};
          rx_idx_n = rx_idx + IW'(1);
          if (rx_idx == IDX_LAST) rx_st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          if (rxs) begin
            rx_valid_n = 1'b1;
            rx_data_n  = rx_sr;
          end
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  assign tx_busy = (tx_st != TX_IDLE);

  // txd is registered: each branch sets the level for the bit that begins at this edge.
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_idx_n = tx_idx;
    tx_sr_n  = tx_sr;
    txd_n    = txd;
    case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (tx_start) begin
          tx_sr_n = tx_data;
          txd_n   = 1'b0;
          tx_st_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_idx_n = '0;
          txd_n    = tx_sr[0];
          tx_st_n  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == IDX_LAST) begin
            txd_n   = 1'b1;
            tx_st_n = TX_STOP;
          end else begin
            tx_idx_n = tx_idx + IW'(1);
            tx_sr_n  = {1'b0, tx_sr[DATA_BITS-1:1]};
            txd_n    = tx_sr[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_st_n  = TX_IDLE;
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/system_top.sv
// UART echo top: received bytes go through a 4-entry FIFO back out on uart_txd; led toggles per good byte.
module system_top
  import system_pkg::*;
#(
  parameter int unsigned clk_freq       = 2000000,
  parameter int unsigned uart_baud_rate = 1152000
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rxd,
  output logic uart_txd,
  output logic led
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic [DATA_BITS-1:0] rx_data, tx_data;
  logic                 rx_valid, tx_start, tx_busy;
  logic                 wr_en, rd_en, full, empty;

  uart_phy #(
    .clk_freq      (clk_freq),
    .uart_baud_rate(uart_baud_rate)
  ) u_phy (
    .clk     (clk),
    .rst     (rst),
    .rxd     (uart_rxd),
    .txd     (uart_txd),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy)
  );

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_en    = !empty && !tx_busy;
  assign tx_start = rd_en;
  assign tx_data  = mem[rd_ptr];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_en    = rx_valid && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      led    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      led <= led ^ rx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_system_top.sv
// Directed scoreboard bench for system_top at N=2 (defaults) and N=10.
module tb_system_top;

  typedef struct {
    logic [8:0] f;
    int         t;
  } frm_t;

  logic clk = 1'b0;
  logic rst2, rst10, rxd2, rxd10;
  logic txd2, txd10, led2, led10;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int starts10 = 0;
  int last_start10 = 0;

  frm_t       got2[$], got10[$];
  logic [7:0] exp2[$], exp10[$];
  int         rv2[$], ts2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  system_top dut (
    .clk(clk), .rst(rst2), .uart_rxd(rxd2), .uart_txd(txd2), .led(led2)
  );

  system_top #(.clk_freq(1000000), .uart_baud_rate(100000)) dut10 (
    .clk(clk), .rst(rst10), .uart_rxd(rxd10), .uart_txd(txd10), .led(led10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame decoders: sample each bit in its first cycle; a reset during the frame discards it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst2 === 1'b1 && txd2 === 1'b0) begin
        frm_t fr;
        logic ok;
        fr.t = cyc;
        fr.f = '0;
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
          repeat (2) begin @(negedge clk); if (rst2 !== 1'b1) ok = 1'b0; end
          fr.f[i] = txd2;
        end
        if (ok) got2.push_back(fr);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst10 === 1'b1 && txd10 === 1'b0) begin
        frm_t fr;
        logic ok;
        fr.t = cyc;
        fr.f = '0;
        ok = 1'b1;
        last_start10 = cyc;
        starts10++;
        for (int i = 0; i < 9; i++) begin
          repeat (10) begin @(negedge clk); if (rst10 !== 1'b1) ok = 1'b0; end
          fr.f[i] = txd10;
        end
        if (ok) got10.push_back(fr);
      end
    end
  end

  always @(negedge clk) if (dut.rx_valid === 1'b1) rv2.push_back(cyc);

  task automatic send(input bit sel, input logic [7:0] b, input logic stopv);
    logic [9:0] fr;
    int n;
    fr = {stopv, b, 1'b0};
    n = sel ? 10 : 2;
    for (int i = 0; i < 10; i++) begin
      if (sel) rxd10 = fr[i]; else rxd2 = fr[i];
      repeat (n) @(negedge clk);
    end
    if (sel) rxd10 = 1'b1; else rxd2 = 1'b1;
  endtask

  task automatic wait_got2(input int n);
    for (int i = 0; i < 4000 && got2.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_got10(input int n);
    for (int i = 0; i < 4000 && got10.size() < n; i++) @(negedge clk);
  endtask

  task automatic drain2;
    frm_t g;
    logic [7:0] e;
    ts2.delete();
    check("frame_count2", got2.size(), exp2.size());
    while (exp2.size() > 0 && got2.size() > 0) begin
      e = exp2.pop_front();
      g = got2.pop_front();
      ts2.push_back(g.t);
      check("echo2", {23'd0, g.f}, {23'd0, 1'b1, e});
    end
    exp2.delete();
    got2.delete();
  endtask

  task automatic drain10;
    frm_t g;
    logic [7:0] e;
    check("frame_count10", got10.size(), exp10.size());
    while (exp10.size() > 0 && got10.size() > 0) begin
      e = exp10.pop_front();
      g = got10.pop_front();
      check("echo10", {23'd0, g.f}, {23'd0, 1'b1, e});
    end
    exp10.delete();
    got10.delete();
  endtask

  initial begin
    int s0;
    rst2 = 1'b0; rst10 = 1'b0; rxd2 = 1'b1; rxd10 = 1'b1;

    repeat (4) begin
      @(negedge clk);
      check("rst_txd2", txd2, 1); check("rst_led2", led2, 0);
      check("rst_txd10", txd10, 1); check("rst_led10", led10, 0);
    end
    rst2 = 1'b1; rst10 = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      check("idle_txd2", txd2, 1); check("idle_led2", led2, 0);
      check("idle_txd10", txd10, 1); check("idle_led10", led10, 0);
    end

    // single byte, N=2
    rv2.delete();
    exp2.push_back(8'h55);
    send(1'b0, 8'h55, 1'b1);
    wait_got2(1);
    check("rx_valid_count", rv2.size(), 1);
    if (rv2.size() > 0 && got2.size() > 0) check("echo_latency", got2[0].t - rv2[0], 2);
    drain2();
    check("led_after_55", led2, 1);
    repeat (100) @(negedge clk);
    check("no_extra_frame", got2.size(), 0);

    // back-to-back, N=2, from a fresh reset
    rst2 = 1'b0; @(negedge clk); rst2 = 1'b1;
    check("led_after_rst", led2, 0);
    exp2.push_back(8'hA5); exp2.push_back(8'h3C);
    send(1'b0, 8'hA5, 1'b1);
    send(1'b0, 8'h3C, 1'b1);
    wait_got2(2);
    drain2();
    if (ts2.size() == 2) check("b2b_gap", ts2[1] - ts2[0], 21);
    check("led_after_b2b", led2, 0);

    // N=10 glitch and framing error
    rxd10 = 1'b0; repeat (3) @(negedge clk); rxd10 = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_tx", starts10, 0);
    check("glitch_led", led10, 0);
    send(1'b1, 8'h41, 1'b0);
    repeat (300) @(negedge clk);
    check("ferr_no_tx", starts10, 0);
    check("ferr_led", led10, 0);

    // N=10 reset during 4th transmitted data bit
    s0 = starts10;
    send(1'b1, 8'h7E, 1'b1);
    for (int i = 0; i < 300 && starts10 == s0; i++) @(negedge clk);
    check("tx10_started", starts10, s0 + 1);
    check("led10_after_7e", led10, 1);
    for (int i = 0; i < 200 && cyc < last_start10 + 44; i++) @(negedge clk);
    rst10 = 1'b0;
    @(negedge clk);
    check("midrst_txd", txd10, 1);
    check("midrst_led", led10, 0);
    check("midrst_fifo", dut10.count, 0);
    rst10 = 1'b1;
    repeat (150) @(negedge clk);
    check("midrst_no_frame", got10.size(), 0);
    exp10.push_back(8'h12);
    send(1'b1, 8'h12, 1'b1);
    wait_got10(1);
    drain10();
    check("led10_after_12", led10, 1);

    // FIFO overflow with the transmitter held off
    force dut.tx_busy = 1'b1;
    for (int i = 1; i <= 4; i++) exp2.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("ovf_count", dut.count, 4);
    check("ovf_led", led2, 1);
    release dut.tx_busy;
    wait_got2(4);
    drain2();
    repeat (200) @(negedge clk);
    check("ovf_dropped", got2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/system_top.md
# system_top

Minimal UART echo system for simulation bring-up and board smoke tests.
- Receives 8N1 serial bytes on `uart_rxd` and buffers them in a 4-entry FIFO.
- Retransmits each byte unchanged on `uart_txd`.
- Toggles `led` on every correctly framed byte received.
- Sits at the chip top level; all timing is derived from `clk_freq` and `uart_baud_rate`.

## Interface
Single clock `clk`; reset `rst` is synchronous and active-low.

Parameters:
- `clk_freq`, 2000000: clock frequency in Hz.
- `uart_baud_rate`, 1152000: serial bit rate.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous active-low reset.
- `uart_rxd`  input  1  serial receive line, idle high, asynchronous to `clk`.
- `uart_txd`  output  1  serial transmit line, idle high.
- `led`  output  1  activity indicator.

## Operation
- Bit period N = round(clk_freq / uart_baud_rate), i.e. (clk_freq + uart_baud_rate/2) / uart_baud_rate, clamped to a minimum of 2. With the defaults, N = 2.
- `uart_rxd` passes through a 2-flop synchronizer, reset to 1. All receive logic uses the synchronized value `rxs`.
- Frame format: 8N1, LSB first. Start bit = 0, stop bit = 1, no parity.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when `rxs` is 0.
  - START: after N/2 cycles (integer division), resample. If `rxs` = 1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits, one every N cycles.
  - STOP: sample N cycles after the last data bit. If 1, issue a 1-cycle `rx_valid` pulse with the byte; if 0, it is a framing error and the byte is discarded.
  - STOP -> IDLE in both cases. The next start edge can be accepted in the following cycle.
- FIFO: depth 4, 8 bits wide.
  - Write on `rx_valid`; if full, the byte is dropped (no overwrite).
  - Simultaneous read and write are allowed at any occupancy, including when full.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - In IDLE with the FIFO non-empty: pop one byte and enter START.
  - Drive the start bit (0) for N cycles, then 8 data bits LSB first for N cycles each, then the stop bit (1) for N cycles.
  - Return to IDLE; back-to-back frames need no extra idle time beyond one IDLE cycle.
- LED: toggles in the cycle after each `rx_valid`, including when the FIFO write is dropped. Framing errors and glitches leave it unchanged.

## Timing
- Reset (`rst` = 0 at a rising edge) puts:
  - both FSMs in IDLE;
  - the FIFO empty;
  - `uart_txd` = 1, `led` = 0, synchronizer flops = 1.
- Reset mid-frame aborts both the receive and the transmit frame immediately. `uart_txd` goes to 1 at the next edge.
- Receive latency: `rx_valid` is asserted in the cycle after the stop-bit sample edge.
- Echo latency: with `rx_valid` in cycle k, the FIFO write happens at the end of k. The transmitter pops in k+1 and `uart_txd` goes low at k+2 (when TX is idle).
- `uart_txd` and `led` are registered outputs; neither has a combinational path from the inputs.
- Input-to-sample delay: 2 cycles of synchronizer latency plus the N/2 start offset.

## Structure
- Shared package `system_pkg`:
  - `DATA_BITS` = 8, `FIFO_DEPTH` = 4;
  - RX/TX FSM state enums;
  - a function computing N from the two parameters, with the minimum-2 clamp.
- One natural sub-module: `uart_phy`, containing the synchronizer, the RX FSM/shifter and the TX FSM/shifter.
  - Ports: `rx_data`, `rx_valid`, `tx_data`, `tx_start`, `tx_busy`.
- The FIFO and LED logic stay in `system_top`.

## Test plan
- Reset held low for 4 cycles, with `uart_rxd` = 1 -> `uart_txd` = 1 and `led` = 0 throughout. Both remain so for 1000 idle cycles after release.
- Defaults (N = 2): send 0x55 -> exactly one frame 0x55 echoed on `uart_txd` (start low 2 cycles after `rx_valid`); `led` becomes 1.
- Back-to-back 0xA5 then 0x3C -> echoed as 0xA5 then 0x3C in order, with no idle gap longer than 1 cycle; `led` returns to 0.
- clk_freq = 1000000, uart_baud_rate = 100000 (N = 10): a 3-cycle low pulse on `uart_rxd` -> no echo, `led` unchanged. Then 0x41 sent with stop bit = 0 -> no echo, `led` unchanged.
- N = 10: send 0x7E; assert `rst` during the 4th transmitted data bit -> `uart_txd` = 1 from the next edge, FIFO empty, `led` = 0. A subsequent 0x12 echoes correctly.
- FIFO overflow (transmitter stalled by forcing the TX state in the bench): write 5 bytes 0x01..0x05, then release -> 0x01..0x04 echoed, 0x05 dropped; `led` toggles 5 times.
